pipe_reg_chain: RTL and testbench

- Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with its own valid bit, joined by a valid/ready handshake at both ends.
- Successor to the plain D-flop register: adds depth, backpressure, bubble collapsing, flush and an occupancy count.
- Used wherever datapath timing is cut across multiple cycles and the consumer can stall.

---
 rtl/seq_pkg.sv | 11 +
 rtl/pipe_stage.sv | 45 ++++
 rtl/pipe_reg_chain.sv | 77 +++++++
 tb/tb_pipe_reg_chain.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared parameters and helpers for the elastic pipeline register chain.
package seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the elastic pipeline; loads from upstream whenever it can pass its word on or is empty.
module pipe_stage
    import seq_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // An empty stage always accepts, which is what collapses bubbles under backpressure.
    always_comb begin
        rdy = !valid_r || dn_ready;
    end

    // Stage register; data only loads on a real word so bubbles never toggle the data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= RESET_VAL;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (rdy) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised elastic pipeline register: DEPTH handshaked stages with flush and an occupancy count.
module pipe_reg_chain
    import seq_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] valid_s;
    logic [WIDTH-1:0] data_s [DEPTH];
    logic [OCC_W-1:0] occ_s;

    // The ready chain runs through per-stage nets so each link is its own signal rather than bits of one vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             rdy_l;
        logic             dn_ready_l;
        logic             up_valid_l;
        logic [WIDTH-1:0] up_data_l;

        if (i == DEPTH - 1) begin : g_last
            assign dn_ready_l = out_ready;
        end else begin : g_mid
            assign dn_ready_l = g_stage[i+1].rdy_l;
        end

        if (i == 0) begin : g_first
            assign up_valid_l = in_valid;
            assign up_data_l  = in_data;
        end else begin : g_next
            assign up_valid_l = valid_s[i-1];
            assign up_data_l  = data_s[i-1];
        end

        pipe_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .up_valid(up_valid_l),
            .up_data (up_data_l),
            .dn_ready(dn_ready_l),
            .valid   (valid_s[i]),
            .data    (data_s[i]),
            .rdy     (rdy_l)
        );
    end

    // Occupancy is a popcount of the registered valid bits.
    always_comb begin
        occ_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_s = occ_s + OCC_W'(valid_s[i]);
        end
    end

    assign in_ready  = g_stage[0].rdy_l && !flush;
    assign out_valid = valid_s[DEPTH-1] && !flush;
    assign out_data  = data_s[DEPTH-1];
    assign occupancy = occ_s;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: queue-of-words model checked every cycle plus literal expectations.
module tb_pipe_reg_chain;
    import seq_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int D  = DEF_DEPTH;
    localparam int OW = occ_width(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [OW-1:0] occupancy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL('0)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words in arrival order (oldest first) with the stage index each occupies.
    logic [W-1:0] m_data[$];
    int           m_pos[$];
    logic [W-1:0] n_data[$];
    int           n_pos[$];
    int           lim;
    bit           acc;

    function automatic bit m_out_valid();
        return !flush && (m_pos.size() > 0) && (m_pos[0] == D - 1);
    endfunction

    function automatic bit m_in_ready();
        return !flush && ((m_pos.size() < D) || out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            m_data.delete();
            m_pos.delete();
        end else begin
            acc = in_valid && m_in_ready();
            n_data.delete();
            n_pos.delete();
            lim = D;
            for (int k = 0; k < m_pos.size(); k++) begin
                if (m_pos[k] + 1 < lim) begin
                    n_pos.push_back(m_pos[k] + 1);
                    n_data.push_back(m_data[k]);
                    lim = m_pos[k] + 1;
                end else if (m_pos[k] + 1 == D && out_ready) begin
                    lim = D;
                end else begin
                    n_pos.push_back(m_pos[k]);
                    n_data.push_back(m_data[k]);
                    lim = m_pos[k];
                end
            end
            if (acc) begin
                n_pos.push_back(0);
                n_data.push_back(in_data);
            end
            m_pos  = n_pos;
            m_data = n_data;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_in_ready()));
        check("out_valid", 32'(out_valid), 32'(m_out_valid()));
        if (m_out_valid()) begin
            check("out_data", 32'(out_data), 32'(m_data[0]));
        end
        check("occupancy", 32'(occupancy), 32'(m_pos.size()));
    end

    // Words the DUT actually delivered, for the literal order checks.
    logic [W-1:0] dut_log[$];
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            dut_log.push_back(out_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp2 [3] = '{8'hAA, 8'h55, 8'h0F};
    logic [W-1:0] exp3 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [W-1:0] exp6 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h77};

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #12;
        rst = 1'b0;
        step();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_occ", 32'(occupancy), 32'd0);

        // 1: async reset with two words in flight
        in_valid = 1'b1; in_data = 8'hE1; step();
        in_data = 8'hE2; step();
        in_valid = 1'b0; step();
        check("t1_occ_before", 32'(occupancy), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("t1_rst_out_valid", 32'(out_valid), 32'd0);
        check("t1_rst_out_data", 32'(out_data), 32'h00);
        check("t1_rst_occ", 32'(occupancy), 32'd0);
        #3;
        rst = 1'b0;
        step();
        check("t1_release_in_ready", 32'(in_ready), 32'd1);

        // 2: streaming with fixed latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hAA;
        check("t2_in_ready0", 32'(in_ready), 32'd1);
        step(); in_data = 8'h55;
        check("t2_in_ready1", 32'(in_ready), 32'd1);
        step(); in_data = 8'h0F;
        check("t2_in_ready2", 32'(in_ready), 32'd1);
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_out_valid", 32'(out_valid), 32'd1);
            check("t2_out_data", 32'(out_data), 32'(exp2[i]));
            step();
        end
        check("t2_drained", 32'(out_valid), 32'd0);

        // 3: fill under backpressure, then drain in order
        dut_log.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = exp3[i];
            step();
        end
        in_data = 8'h04;
        check("t3_full_in_ready", 32'(in_ready), 32'd0);
        check("t3_full_occ", 32'(occupancy), 32'd3);
        step();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("t3_log_size", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_log.size()) check("t3_log_word", 32'(dut_log[i]), 32'(exp3[i]));
        end

        // 4: bubble collapses while stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'h22; step();
        in_valid = 1'b0; step(); step();
        check("t4_occ", 32'(occupancy), 32'd2);
        check("t4_out_data", 32'(out_data), 32'h11);
        check("t4_valid_map", 32'(u_dut.valid_s), 32'b110);

        // 5: flush drops everything and blocks the new word
        in_valid = 1'b1; in_data = 8'h33; step();
        check("t5_occ_full", 32'(occupancy), 32'd3);
        dut_log.delete();
        flush = 1'b1; in_data = 8'h99;
        #1;
        check("t5_flush_in_ready", 32'(in_ready), 32'd0);
        check("t5_flush_out_valid", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t5_occ_cleared", 32'(occupancy), 32'd0);
        out_ready = 1'b1;
        repeat (4) step();
        check("t5_nothing_out", 32'(dut_log.size()), 32'd0);

        // 6: full pipe passes one word through in the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = exp6[i];
            step();
        end
        dut_log.delete();
        in_data = 8'h77; out_ready = 1'b1;
        #1;
        check("t6_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("t6_occ_kept", 32'(occupancy), 32'd3);
        check("t6_first_out_count", 32'(dut_log.size()), 32'd1);
        repeat (4) step();
        check("t6_log_size", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_log.size()) check("t6_log_word", 32'(dut_log[i]), 32'(exp6[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
